// File: rtl/reaction_timer.sv
// Reaction-time game controller: arms a random delay, lights the go-lamp, times the press in ms.
// Optional best-time tracking is enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer #(
    parameter int CLKS_PER_MS = 25000,
    parameter int MAX_MS      = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button,
    input  logic        delay_done,
    output logic        start_delay,
    output logic        led,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic [13:0] best_ms
);

    localparam int            PW         = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [13:0]   MS_MAX     = 14'(MAX_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GO,
        S_DONE,
        S_FAULT
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   ms_q, ms_d;
    logic [13:0]   result_q, result_d;
    logic          valid_q, valid_d;
    logic          fs_q, fs_d;
    logic          to_q, to_d;
    logic          press;
    logic          tick;

    assign press = sync2_q & ~prev_q;
    assign tick  = (presc_q == PRESC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            presc_q  <= '0;
            ms_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            to_q     <= to_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        ms_d        = ms_q;
        result_d    = result_q;
        valid_d     = 1'b0;
        fs_d        = fs_q;
        to_d        = to_q;
        start_delay = 1'b0;
        led         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_ARM;
                    fs_d    = 1'b0;
                    to_d    = 1'b0;
                end
            end
            S_ARM: begin
                start_delay = 1'b1;
                if (press) begin
                    state_d = S_FAULT;
                    fs_d    = 1'b1;
                end else if (delay_done) begin
                    state_d = S_GO;
                    presc_d = '0;
                    ms_d    = '0;
                end
            end
            S_GO: begin
                led = 1'b1;
                if (tick) begin
                    presc_d = '0;
                    if (ms_q != MS_MAX) ms_d = ms_q + 14'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                // The wrap that lands on MAX_MS ends the round; a press in that cycle loses.
                if (tick && (ms_q >= MS_MAX - 14'd1)) begin
                    state_d  = S_DONE;
                    to_d     = 1'b1;
                    result_d = MS_MAX;
                    valid_d  = 1'b1;
                end else if (press) begin
                    state_d  = S_DONE;
                    result_d = ms_q;
                    valid_d  = 1'b1;
                end
            end
            S_DONE, S_FAULT: begin
                if (press) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result_ms    = result_q;
    assign result_valid = valid_q;
    assign false_start  = fs_q;
    assign timeout      = to_q;

`ifdef REACTION_BEST_TIME_EN
    logic [13:0] best_q;
    logic        have_best_q;
    logic        take_best;

    assign take_best = valid_d && !to_d && (!have_best_q || (result_d < best_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q      <= '0;
            have_best_q <= 1'b0;
        end else if (take_best) begin
            best_q      <= result_d;
            have_best_q <= 1'b1;
        end
    end

    assign best_ms = best_q;
`else
    assign best_ms = '0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Randomised self-checking bench for reaction_timer; expectations come from round-level timing arithmetic.
module tb_reaction_timer;

    localparam int CLKS       = 4;
    localparam int MAXMS      = 20;
    localparam int TO_CYCLES  = CLKS * MAXMS;
    localparam int NO_PRESS   = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        button = 1'b0;
    logic        delay_done = 1'b0;
    logic        start_delay;
    logic        led;
    logic [13:0] result_ms;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic [13:0] best_ms;

    int checks = 0;
    int errors = 0;
    int rv_count = 0;

    // Reference model: last published result and the minimum of measured (non-timeout) results.
    int last_result = 0;
    int best_val = 0;
    bit have_best = 1'b0;

    reaction_timer #(.CLKS_PER_MS(CLKS), .MAX_MS(MAXMS)) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .delay_done(delay_done),
        .start_delay(start_delay), .led(led), .result_ms(result_ms),
        .result_valid(result_valid), .false_start(false_start),
        .timeout(timeout), .best_ms(best_ms)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (result_valid === 1'b1) rv_count++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int exp_best();
`ifdef REACTION_BEST_TIME_EN
        return have_best ? best_val : 0;
`else
        return 0;
`endif
    endfunction

    // kind 0: measured round, press r samples after the lamp (NO_PRESS = never).
    // kind 1: press r samples into ARM, delay_done later; kind 2: delay_done on the press cycle.
    task automatic run_round(input int kind, input int dly, input int r);
        int  n, k, seen, rv0, fs_seen, led_ever, led_gap;
        int  exp_seen, exp_ms;
        bit  exp_to, exp_fs;
        rv0 = rv_count;

        button = 1'b1;
        n = 0;
        do begin step(); n++; end while (start_delay !== 1'b1 && n < 10);
        check("arm_latency", n, 3);
        check("arm_flags", {false_start, timeout, led}, 0);
        button = 1'b0;

        if (kind == 0) begin
            repeat (dly) step();
            delay_done = 1'b1;
            step();
            delay_done = 1'b0;
            check("go_entry", {led, start_delay}, 2'b10);
            k = 0; seen = -1; led_gap = 0;
            while (seen < 0 && k < TO_CYCLES + 10) begin
                if (k == r) button = 1'b1;
                else if (k == r + 4) button = 1'b0;
                step();
                k++;
                if (result_valid === 1'b1) seen = k;
                else if (led !== 1'b1) led_gap++;
            end
            exp_to   = (r + 2 >= TO_CYCLES - 1);
            exp_seen = exp_to ? TO_CYCLES : r + 3;
            exp_ms   = exp_to ? MAXMS : (r + 2) / CLKS;
            exp_fs   = 1'b0;
            last_result = exp_ms;
            if (!exp_to && (!have_best || exp_ms < best_val)) begin
                best_val  = exp_ms;
                have_best = 1'b1;
            end
            check("done_cycle", seen, exp_seen);
            check("led_steady", led_gap, 0);
            check("result_ms", result_ms, exp_ms);
            check("timeout_flag", timeout, exp_to);
            check("done_outputs", {led, start_delay, false_start}, 0);
            check("best_ms", best_ms, exp_best());
            step();
            check("valid_one_cycle", result_valid, 0);
            check("result_hold", result_ms, exp_ms);
        end else begin
            fs_seen = -1; led_ever = 0;
            for (int j = 0; j < r + 12; j++) begin
                button     = (j >= r && j < r + 3);
                delay_done = (j == dly);
                step();
                if (false_start === 1'b1 && fs_seen < 0) fs_seen = j + 1;
                if (led !== 1'b0) led_ever = 1;
            end
            delay_done = 1'b0;
            exp_to = 1'b0;
            exp_fs = 1'b1;
            check(kind == 2 ? "fault_same_cycle" : "fault_cycle", fs_seen, r + 3);
            check("fault_no_led", led_ever, 0);
            check("fault_outputs", {start_delay, timeout}, 0);
            check("fault_result_hold", result_ms, last_result);
        end

        button = 1'b0;
        step();
        button = 1'b1;
        repeat (3) step();
        button = 1'b0;
        repeat (3) step();
        check("idle_outputs", {led, start_delay, result_valid}, 0);
        check("flags_retained", {false_start, timeout}, {exp_fs, exp_to});
        check("valid_count", rv_count - rv0, (kind == 0) ? 1 : 0);
        check("idle_result_hold", result_ms, last_result);
    endtask

    task automatic reset_mid_go();
        int rv0;
        button = 1'b1;
        repeat (3) step();
        button = 1'b0;
        repeat (2) step();
        delay_done = 1'b1;
        step();
        delay_done = 1'b0;
        repeat (30) step();
        check("pre_reset_led", led, 1);
        rv0 = rv_count;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", {led, start_delay, result_valid, false_start, timeout}, 0);
        check("rst_async_result", result_ms, 0);
        check("rst_async_best", best_ms, 0);
        repeat (3) step();
        rst_n = 1'b1;
        last_result = 0;
        best_val = 0;
        have_best = 1'b0;
        repeat (100) step();
        check("rst_no_valid", rv_count - rv0, 0);
        check("rst_idle", {led, start_delay, timeout}, 0);
    endtask

    initial begin
        int kind, dly, r;
        repeat (3) step();
        check("reset_ctrl", {start_delay, led, result_valid, false_start, timeout}, 0);
        check("reset_result", result_ms, 0);
        check("reset_best", best_ms, 0);
        rst_n = 1'b1;
        step();

        run_round(0, 10, 12);               // measures 3 ms
        run_round(1, 12, 2);                // false start
        run_round(2, 5, 3);                 // press and delay_done together
        run_round(0, 5, NO_PRESS);          // timeout
        run_round(0, 3, TO_CYCLES - 3);     // press lands on the timeout cycle
        run_round(0, 0, 0);

        reset_mid_go();

        run_round(0, 4, 26);                // 7
        run_round(0, 7, 18);                // 5
        run_round(0, 2, 34);                // 9
        run_round(0, 1, NO_PRESS);          // timeout

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                dly = $urandom_range(0, 15);
                r   = ($urandom_range(0, 4) == 0) ? NO_PRESS : $urandom_range(0, TO_CYCLES - 3);
            end else begin
                r   = $urandom_range(1, 10);
                dly = (kind == 2) ? r + 2 : r + 2 + $urandom_range(1, 6);
            end
            run_round(kind, dly, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 SHALL have parameter CLKS_PER_MS, default 25000, meaning clock cycles per millisecond tick.
REQ-002 SHALL have parameter MAX_MS, default 9999, meaning reaction-time ceiling in ms.
REQ-003 SHALL have port clk, input, 1, meaning single system clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port button, input, 1, meaning raw asynchronous player button, high = pressed.
REQ-006 SHALL have port delay_done, input, 1, meaning done from the upstream random-delay stage.
REQ-007 SHALL have port start_delay, output, 1, meaning start to the random-delay stage.
REQ-008 SHALL have port led, output, 1, meaning go-lamp.
REQ-009 SHALL have port result_ms, output, 14, meaning last measured or clamped reaction time.
REQ-010 SHALL have port result_valid, output, 1, meaning one-cycle pulse when result_ms updates.
REQ-011 SHALL have port false_start, output, 1, meaning level, press before lamp.
REQ-012 SHALL have port timeout, output, 1, meaning level, no press within MAX_MS.
REQ-013 SHALL have port best_ms, output, 14, meaning best (minimum) valid time, feature-dependent.

Function
REQ-014 SHALL synchronise button through two flops; a press event is a registered rise of the synchronised signal (0 in cycle N-1, 1 in cycle N).
REQ-015 SHALL implement states IDLE, ARM, GO, DONE, FAULT.
REQ-016 IDLE: all outputs low except held result_ms/best_ms; press -> ARM, clear false_start/timeout.
REQ-017 ARM: start_delay=1; press -> FAULT (false_start=1); else delay_done=1 -> GO.
REQ-018 ARM, press and delay_done in same cycle: press wins -> FAULT.
REQ-019 GO: start_delay=0, led=1; prescaler and ms counter cleared on entry; ms counter increments each time prescaler wraps at CLKS_PER_MS-1.
REQ-020 GO, press -> DONE; result_ms = current ms counter; result_valid high for exactly the cycle DONE is entered.
REQ-021 GO, ms counter reaching MAX_MS -> DONE with timeout=1, result_ms=MAX_MS, result_valid pulsed; press in that same cycle is treated as timeout.
REQ-022 DONE/FAULT: led=0, start_delay=0; press -> IDLE (flags retained until next ARM entry); result_ms held until next update.
REQ-023 Counters SHALL saturate, never wrap; MAX_MS SHALL be at most 16383.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and all outputs, counters and synchroniser flops to 0, independent of clk.
REQ-025 Reset mid-GO SHALL discard the measurement with no result_valid pulse; the first press after release needs the full two-flop latency.

Configuration
REQ-026 With macro REACTION_BEST_TIME_EN defined, best_ms SHALL load result_ms on the first non-timeout result after reset and thereafter only when strictly smaller, updated in the result_valid cycle.
REQ-027 Without REACTION_BEST_TIME_EN, best_ms SHALL be constant 0 with no tracking logic.

Verification (CLKS_PER_MS=4, MAX_MS=20)
REQ-028 Press in IDLE, delay_done after 10 cycles, press 14 cycles after led rises -> result_ms=3, result_valid one cycle, led falls.
REQ-029 Press during ARM before delay_done -> false_start=1, led never rises, no result_valid.
REQ-030 Press and delay_done same cycle in ARM -> FAULT, false_start=1.
REQ-031 No press in GO -> after 80 tick cycles timeout=1, result_ms=20, result_valid once.
REQ-032 With REACTION_BEST_TIME_EN: rounds measuring 7, 5, 9, then timeout -> best_ms 7, 5, 5, 5.
REQ-033 rst_n low mid-GO -> all outputs 0 asynchronously, state IDLE, no result_valid.
